// File: rtl/shift_pkg.sv
// Shared types and constants for the shift execute stage.
// Used by shift_core and shift_exec_stage.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int TAG_W   = 5;

    typedef enum logic [1:0] {
        SH_SRA  = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRL  = 2'b10,
        SH_SLL2 = 2'b11
    } aluc_e;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [SHAMT_W-1:0] shamt;
        aluc_e              aluc;
        logic [TAG_W-1:0]   tag;
    } shift_op_t;

endpackage : shift_pkg

// File: rtl/shift_core.sv
// Purely combinational 32-bit shifter (arithmetic right, logical right, left).
// The out-shifted carry bit is present only when SHIFT_CARRY_EN is defined.
module shift_core
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         aluc,
    output logic [DATA_W-1:0]  c
`ifdef SHIFT_CARRY_EN
    ,
    output logic               carry
`endif
);

    // One guard bit on the out-shifted side holds the last bit shifted out.
    logic [DATA_W:0] left_s;
    logic [DATA_W:0] right_l_s;
    logic [DATA_W:0] right_a_s;
    logic [DATA_W-1:0] c_s;
    logic carry_s;
    aluc_e aluc_e_s;

    assign left_s    = {1'b0, a} << shamt;
    assign right_l_s = {a, 1'b0} >> shamt;
    assign right_a_s = $signed({a, 1'b0}) >>> shamt;
    assign aluc_e_s  = aluc_e'(aluc);

    // Select the shift flavour and its matching carry bit.
    always_comb begin
        c_s     = {DATA_W{1'b0}};
        carry_s = 1'b0;
        case (aluc_e_s)
            SH_SRA: begin
                c_s     = right_a_s[DATA_W:1];
                carry_s = right_a_s[0];
            end
            SH_SRL: begin
                c_s     = right_l_s[DATA_W:1];
                carry_s = right_l_s[0];
            end
            SH_SLL, SH_SLL2: begin
                c_s     = left_s[DATA_W-1:0];
                carry_s = left_s[DATA_W];
            end
            default: begin
                c_s     = {DATA_W{1'b0}};
                carry_s = 1'b0;
            end
        endcase
    end

    assign c = c_s;

`ifdef SHIFT_CARRY_EN
    assign carry = carry_s;
`else
    logic unused_carry_s;
    assign unused_carry_s = carry_s;
`endif

endmodule : shift_core

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift execute stage with valid/ready on both sides.
// Optional out_carry port is enabled by defining SHIFT_CARRY_EN.
module shift_exec_stage
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_aluc,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_c,
    output logic [TAG_W-1:0]  out_tag
`ifdef SHIFT_CARRY_EN
    ,
    output logic              out_carry
`endif
);

    logic              s1_valid_q, s1_valid_d;
    shift_op_t         s1_op_q, s1_op_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_c_q, s2_c_d;
    logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
    logic              s2_carry_q, s2_carry_d;

    logic              s1_advance_s;
    logic              s2_advance_s;
    shift_op_t         in_op_s;
    logic [DATA_W-1:0] core_c_s;
    logic              core_carry_s;
    logic              unused_b_s;

    // Upper amount bits are architecturally ignored.
    assign unused_b_s = ^in_b[DATA_W-1:SHAMT_W];

    assign in_op_s.a     = in_a;
    assign in_op_s.shamt = in_b[SHAMT_W-1:0];
    assign in_op_s.aluc  = aluc_e'(in_aluc);
    assign in_op_s.tag   = in_tag;

    // Handshake: a stage moves when the stage after it is empty or moving.
    always_comb begin
        s2_advance_s = !s2_valid_q || out_ready;
        s1_advance_s = !s1_valid_q || s2_advance_s;
    end

    assign in_ready = s1_advance_s;

    shift_core u_core (
        .a     (s1_op_q.a),
        .shamt (s1_op_q.shamt),
        .aluc  (s1_op_q.aluc),
        .c     (core_c_s)
`ifdef SHIFT_CARRY_EN
        ,
        .carry (core_carry_s)
`endif
    );

`ifndef SHIFT_CARRY_EN
    assign core_carry_s = 1'b0;
`endif

    // Next-state for both stages; flush only kills the valid bits.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_c_d     = s2_c_q;
        s2_tag_d   = s2_tag_q;
        s2_carry_d = s2_carry_q;

        if (s1_advance_s && in_valid) begin
            s1_op_d = in_op_s;
        end else begin
            s1_op_d = s1_op_q;
        end

        if (s2_advance_s && s1_valid_q) begin
            s2_c_d     = core_c_s;
            s2_tag_d   = s1_op_q.tag;
            s2_carry_d = core_carry_s;
        end else begin
            s2_c_d     = s2_c_q;
            s2_tag_d   = s2_tag_q;
            s2_carry_d = s2_carry_q;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_advance_s) begin
                s1_valid_d = in_valid;
            end else begin
                s1_valid_d = s1_valid_q;
            end
            if (s2_advance_s) begin
                s2_valid_d = s1_valid_q;
            end else begin
                s2_valid_d = s2_valid_q;
            end
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_c_q     <= {DATA_W{1'b0}};
            s2_tag_q   <= {TAG_W{1'b0}};
            s2_carry_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_c_q     <= s2_c_d;
            s2_tag_q   <= s2_tag_d;
            s2_carry_q <= s2_carry_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_c     = s2_c_q;
    assign out_tag   = s2_tag_q;

`ifdef SHIFT_CARRY_EN
    assign out_carry = s2_carry_q;
`else
    logic unused_carry_q_s;
    assign unused_carry_q_s = s2_carry_q;
`endif

endmodule : shift_exec_stage

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
Pipelined execute stage wrapping a 32-bit shift datapath with valid/ready handshakes on both sides. It sits between the operand-fetch/decode stage and writeback. Operands and the 2-bit shift opcode are registered in stage 1. The result is computed and registered in stage 2. Throughput is one op per cycle, and backpressure is fully supported.

Parameters:
DATA_W, 32, operand/result width; only 32 is supported.
SHAMT_W, 5, number of shift-amount bits used from the amount source (log2 DATA_W).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all in-flight ops
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept an op this cycle
in_a  input  32  value to shift (treated as signed for arithmetic right)
in_b  input  32  amount source; only bits [4:0] are used
in_aluc  input  2  00 = arithmetic right, 10 = logical right, 01 = left, 11 = left
in_tag  input  5  destination register tag, carried alongside the op
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_c  output  32  shift result
out_tag  output  5  tag of the result

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
  - Asserting rst_n low clears s1_valid, s2_valid, out_c, out_tag and all stage registers to 0 immediately, without waiting for a clock edge.
  - in_ready is 1 during and after reset.
  - Any op in flight when reset asserts is lost; nothing is emitted for it after release.
- Pipeline, stage 1 (S1):
  - Registers a, b[4:0], aluc and tag.
  - Captures when in_valid && in_ready.
- Pipeline, stage 2 (S2):
  - Computes the shift from the S1 registers and registers result and tag.
  - out_valid = s2_valid; out_c and out_tag are driven directly from the S2 registers.
- Advance rules:
  - s2_advance = !s2_valid || out_ready
  - s1_advance = !s1_valid || s2_advance
  - in_ready = s1_advance (combinational; no dependency on in_valid)
- Latency: an op accepted at edge N appears on out_valid after edge N+1, i.e. 2 cycles.
  - Back-to-back ops with out_ready held at 1 stream one per cycle with no bubbles.
- Backpressure:
  - out_ready = 0 with s2_valid = 1 holds out_c and out_tag stable.
  - S1 may still fill if it is empty. Once both stages are full, in_ready = 0.
  - No op is ever dropped or duplicated, and order is preserved.
- Arithmetic:
  - aluc 00: sign-propagating right shift of a by b[4:0].
  - aluc 10: zero-fill right shift.
  - aluc 01 and 11: zero-fill left shift.
  - Amount 0 returns a unchanged.
  - b[31:5] are ignored, so amount 37 behaves as 5.
- Flush:
  - flush = 1 at an edge clears s1_valid and s2_valid. Data registers are don't-care.
  - flush has priority over a simultaneous capture: the op offered that cycle is discarded.
  - in_ready is not gated by flush.
- Simultaneous events: S2 draining while S1 moves into S2 while a new op enters S1 all happen in the same cycle. This is the normal full-throughput case.
- Output is X-free after reset; out_c holds its last value while out_valid = 0.

Optional Feature:
- Macro: SHIFT_CARRY_EN.
- When defined:
  - Adds output port out_carry (1 bit), registered in S2 alongside out_c and reset to 0.
  - Value is the last bit shifted out:
    - Left shift: a[32 - amt].
    - Right shift (both kinds): a[amt - 1].
    - amt = 0: carry is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package shift_pkg holds:
  - constants DATA_W and SHAMT_W;
  - enum of aluc codes SH_SRA = 2'b00, SH_SLL = 2'b01, SH_SRL = 2'b10, SH_SLL2 = 2'b11;
  - the op struct {a, shamt, aluc, tag}.
- One natural sub-module: the purely combinational shifter core shift_core (a, shamt, aluc → c[, carry]), instantiated between S1 and S2.
- The handshake/valid logic stays in the top module.

Test Plan:
- Single op, out_ready = 1:
  - a = 0x80000000, b = 4, aluc = 00, tag = 3 → after 2 cycles out_c = 0xF8000000, out_tag = 3, and out_valid pulses for 1 cycle.
  - Same with aluc = 10 → 0x08000000.
  - a = 0x00000001, b = 31, aluc = 01 → 0x80000000 (carry = 0 if SHIFT_CARRY_EN).
- Amount masking: a = 0x0000F000, b = 0x00000025, aluc = 10 → out_c = 0x00000780. Zero amount: a = 0x12345678, b = 0 → 0x12345678 for every aluc.
- Backpressure: out_ready = 0, send tags 1, 2, 3 on consecutive cycles.
  - Tags 1 and 2 are accepted; in_ready = 0 when tag 3 is offered.
  - out_c/out_tag stay stable for tag 1.
  - Raising out_ready drains 1, 2, 3 in order, one per cycle.
- Streaming: 8 back-to-back ops with out_ready = 1 → 8 consecutive out_valid cycles starting 2 cycles after the first accept, with correct results.
- Flush and reset:
  - flush asserted while both stages are full and a new op is offered → out_valid = 0 next cycle, and none of the three ops ever appears.
  - rst_n pulsed low mid-stream between edges → out_valid = 0 and out_c = 0 immediately; in_ready = 1.
- SHIFT_CARRY_EN:
  - a = 0x00000010, b = 5, aluc = 10 → carry = 1.
  - Same a with b = 4 → carry = 0.
  - a = 0x40000000, b = 2, aluc = 01 → carry = 1.
